// File: rtl/minmax_window_ctl.sv
// Multi-channel windowed min/max tracker: per-channel running extremes, window close on
// sample count or manual strobe, snapshot bank with valid/ack/overrun handshake.
module minmax_window_ctl #(
  parameter int WIDTH     = 14,
  parameter int CHAN_BITS = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 enable_i,
  input  logic [WIDTH-1:0]     xin_i,
  input  logic                 xin_valid_i,
  input  logic [CHAN_BITS-1:0] xin_chan_i,
  input  logic [CNT_WIDTH-1:0] window_i,
  input  logic                 force_close_i,
  input  logic                 snap_ack_i,
  output logic                 snap_valid_o,
  output logic                 snap_overrun_o,
  input  logic [CHAN_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_min_o,
  output logic [WIDTH-1:0]     rd_max_o,
  output logic                 rd_empty_o,
  output logic [CNT_WIDTH-1:0] win_count_o
);

  localparam int CHANS = 1 << CHAN_BITS;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     accMin_q   [CHANS];
  logic [WIDTH-1:0]     accMax_q   [CHANS];
  logic                 accEmpty_q [CHANS];
  logic [WIDTH-1:0]     accMin_d   [CHANS];
  logic [WIDTH-1:0]     accMax_d   [CHANS];
  logic                 accEmpty_d [CHANS];
  logic [WIDTH-1:0]     updMin     [CHANS];
  logic [WIDTH-1:0]     updMax     [CHANS];
  logic                 updEmpty   [CHANS];
  logic [WIDTH-1:0]     bankMin_q  [CHANS];
  logic [WIDTH-1:0]     bankMax_q  [CHANS];
  logic                 bankEmpty_q[CHANS];
  logic [WIDTH-1:0]     bankMin_d  [CHANS];
  logic [WIDTH-1:0]     bankMax_d  [CHANS];
  logic                 bankEmpty_d[CHANS];
  logic [CNT_WIDTH-1:0] winCount_q, winCount_d;
  logic                 snapValid_q, snapValid_d;
  logic                 snapOverrun_q, snapOverrun_d;
  logic [WIDTH-1:0]     rdMin_q;
  logic [WIDTH-1:0]     rdMax_q;
  logic                 rdEmpty_q;
  logic                 runActive;
  logic                 sampleTake;
  logic                 closeWin;
  logic [CNT_WIDTH:0]   countInc;

  // updX holds the accumulators with this edge's sample folded in, so a closing sample
  // lands in the snapshot and the following sample starts the next window.
  always_comb begin
    runActive  = (state_q == RUN) && enable_i;
    sampleTake = runActive && xin_valid_i;
    countInc   = {1'b0, winCount_q} + (CNT_WIDTH+1)'(1);
    closeWin   = runActive &&
                 ((sampleTake && (window_i != '0) && (countInc >= {1'b0, window_i})) ||
                  force_close_i);

    for (int c = 0; c < CHANS; c++) begin
      updMin[c]   = accMin_q[c];
      updMax[c]   = accMax_q[c];
      updEmpty[c] = accEmpty_q[c];
      if (sampleTake && (xin_chan_i == CHAN_BITS'(c))) begin
        if (xin_i < accMin_q[c]) updMin[c] = xin_i;
        if (xin_i > accMax_q[c]) updMax[c] = xin_i;
        updEmpty[c] = 1'b0;
      end

      if (!runActive || closeWin) begin
        accMin_d[c]   = '1;
        accMax_d[c]   = '0;
        accEmpty_d[c] = 1'b1;
      end else begin
        accMin_d[c]   = updMin[c];
        accMax_d[c]   = updMax[c];
        accEmpty_d[c] = updEmpty[c];
      end

      bankMin_d[c]   = closeWin ? updMin[c]   : bankMin_q[c];
      bankMax_d[c]   = closeWin ? updMax[c]   : bankMax_q[c];
      bankEmpty_d[c] = closeWin ? updEmpty[c] : bankEmpty_q[c];
    end

    winCount_d = winCount_q;
    if (!runActive || closeWin)
      winCount_d = '0;
    else if (sampleTake && (winCount_q != '1))
      winCount_d = winCount_q + CNT_WIDTH'(1);

    // An ack arriving together with a close consumes the old data, so no overrun.
    snapValid_d   = snapValid_q;
    snapOverrun_d = snapOverrun_q;
    if (closeWin) begin
      snapValid_d   = 1'b1;
      snapOverrun_d = snapValid_q && !snap_ack_i;
    end else if (snap_ack_i) begin
      snapValid_d   = 1'b0;
      snapOverrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      winCount_q    <= '0;
      snapValid_q   <= 1'b0;
      snapOverrun_q <= 1'b0;
      rdMin_q       <= '1;
      rdMax_q       <= '0;
      rdEmpty_q     <= 1'b1;
      for (int c = 0; c < CHANS; c++) begin
        accMin_q[c]    <= '1;
        accMax_q[c]    <= '0;
        accEmpty_q[c]  <= 1'b1;
        bankMin_q[c]   <= '1;
        bankMax_q[c]   <= '0;
        bankEmpty_q[c] <= 1'b1;
      end
    end else begin
      if (!enable_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    state_q <= ARM;
          ARM:     state_q <= RUN;
          RUN:     state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
      winCount_q    <= winCount_d;
      snapValid_q   <= snapValid_d;
      snapOverrun_q <= snapOverrun_d;
      rdMin_q       <= bankMin_q[rd_addr_i];
      rdMax_q       <= bankMax_q[rd_addr_i];
      rdEmpty_q     <= bankEmpty_q[rd_addr_i];
      for (int c = 0; c < CHANS; c++) begin
        accMin_q[c]    <= accMin_d[c];
        accMax_q[c]    <= accMax_d[c];
        accEmpty_q[c]  <= accEmpty_d[c];
        bankMin_q[c]   <= bankMin_d[c];
        bankMax_q[c]   <= bankMax_d[c];
        bankEmpty_q[c] <= bankEmpty_d[c];
      end
    end
  end

  assign snap_valid_o   = snapValid_q;
  assign snap_overrun_o = snapOverrun_q;
  assign rd_min_o       = rdMin_q;
  assign rd_max_o       = rdMax_q;
  assign rd_empty_o     = rdEmpty_q;
  assign win_count_o    = winCount_q;

endmodule

// File: tb/tb_minmax_window_ctl.sv
// Scoreboard bench for minmax_window_ctl: stimulus pushes expected readout/status
// entries with a due cycle, and a negedge monitor pops and compares them.
module tb_minmax_window_ctl;

  localparam int W  = 14;
  localparam int CB = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetN;
  logic          enable;
  logic [W-1:0]  xin;
  logic          xinValid;
  logic [CB-1:0] xinChan;
  logic [CW-1:0] window;
  logic          forceClose;
  logic          snapAck;
  logic          snapValid;
  logic          snapOverrun;
  logic [CB-1:0] rdAddr;
  logic [W-1:0]  rdMin;
  logic [W-1:0]  rdMax;
  logic          rdEmpty;
  logic [CW-1:0] winCount;

  typedef struct {
    int            kind;
    int            due;
    string         name;
    logic [W-1:0]  eMin;
    logic [W-1:0]  eMax;
    logic          eEmpty;
    logic          eValid;
    logic          eOverrun;
    logic [CW-1:0] eCount;
  } exp_t;

  exp_t          sbQ[$];
  exp_t          mon;
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  expMin[4];
  logic [W-1:0]  expMax[4];

  minmax_window_ctl #(.WIDTH(W), .CHAN_BITS(CB), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .reset_n_i      (resetN),
    .enable_i       (enable),
    .xin_i          (xin),
    .xin_valid_i    (xinValid),
    .xin_chan_i     (xinChan),
    .window_i       (window),
    .force_close_i  (forceClose),
    .snap_ack_i     (snapAck),
    .snap_valid_o   (snapValid),
    .snap_overrun_o (snapOverrun),
    .rd_addr_i      (rdAddr),
    .rd_min_o       (rdMin),
    .rd_max_o       (rdMax),
    .rd_empty_o     (rdEmpty),
    .win_count_o    (winCount)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp when each expected entry becomes due
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at each falling edge, pop every entry that is due and compare it
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
      mon = sbQ.pop_front();
      checks++;
      if (mon.kind == 0) begin
        if (rdMin !== mon.eMin || rdMax !== mon.eMax || rdEmpty !== mon.eEmpty) begin
          errors++;
          $display("[TB] FAIL %s: got min=%0d max=%0d empty=%0b, want min=%0d max=%0d empty=%0b",
                   mon.name, rdMin, rdMax, rdEmpty, mon.eMin, mon.eMax, mon.eEmpty);
        end
      end else begin
        if (snapValid !== mon.eValid || snapOverrun !== mon.eOverrun || winCount !== mon.eCount) begin
          errors++;
          $display("[TB] FAIL %s: got valid=%0b overrun=%0b count=%0d, want valid=%0b overrun=%0b count=%0d",
                   mon.name, snapValid, snapOverrun, winCount, mon.eValid, mon.eOverrun, mon.eCount);
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample on one channel, accepted on the next rising edge
  task automatic applyStimulus(input int ch, input int val);
    xin      = W'(val);
    xinChan  = CB'(ch);
    xinValid = 1'b1;
    tick();
    xinValid = 1'b0;
  endtask

  // Readout expectation: either for the current rd outputs, or after selecting a channel
  task automatic checkOutput(input string name, input int ch, input int eMin, input int eMax,
                             input bit eEmpty, input bit immediate);
    exp_t e;
    e.kind   = 0;
    e.name   = name;
    e.eMin   = W'(eMin);
    e.eMax   = W'(eMax);
    e.eEmpty = eEmpty;
    e.eValid = 1'b0;
    e.eOverrun = 1'b0;
    e.eCount = '0;
    if (immediate) begin
      e.due = cyc;
      sbQ.push_back(e);
    end else begin
      rdAddr = CB'(ch);
      e.due  = cyc + 1;
      sbQ.push_back(e);
      tick();
    end
  endtask

  task automatic checkStatus(input string name, input bit eValid, input bit eOverrun, input int eCount);
    exp_t e;
    e.kind     = 1;
    e.name     = name;
    e.due      = cyc;
    e.eMin     = '0;
    e.eMax     = '0;
    e.eEmpty   = 1'b0;
    e.eValid   = eValid;
    e.eOverrun = eOverrun;
    e.eCount   = CW'(eCount);
    sbQ.push_back(e);
  endtask

  task automatic ackSnap();
    snapAck = 1'b1;
    tick();
    snapAck = 1'b0;
  endtask

  task automatic checkAllEmpty(input string name);
    for (int c = 0; c < 4; c++) checkOutput(name, c, 16383, 0, 1'b1, 1'b0);
  endtask

  // Directed test sequence
  initial begin
    resetN = 1'b0; enable = 1'b0; xin = '0; xinValid = 1'b0; xinChan = '0;
    window = '0; forceClose = 1'b0; snapAck = 1'b0; rdAddr = '0;
    tick(); tick();
    checkStatus("reset_status", 1'b0, 1'b0, 0);
    checkOutput("reset_read", 0, 16383, 0, 1'b1, 1'b1);
    tick();
    resetN = 1'b1;
    tick();

    // Window of four samples
    window = CW'(4);
    enable = 1'b1;
    tick(); tick();
    applyStimulus(0, 100);
    applyStimulus(0, 50);
    applyStimulus(0, 200);
    checkStatus("t1_count3", 1'b0, 1'b0, 3);
    applyStimulus(1, 7);
    checkStatus("t1_close", 1'b1, 1'b0, 0);
    checkOutput("t1_ch0", 0, 50, 200, 1'b0, 1'b0);
    checkOutput("t1_ch1", 1, 7, 7, 1'b0, 1'b0);
    checkOutput("t1_ch2", 2, 16383, 0, 1'b1, 1'b0);
    checkOutput("t1_ch3", 3, 16383, 0, 1'b1, 1'b0);
    ackSnap();
    checkStatus("t1_ack", 1'b0, 1'b0, 0);

    // Back-to-back windows without ack
    window = CW'(2);
    applyStimulus(0, 10);
    applyStimulus(1, 20);
    applyStimulus(2, 30);
    applyStimulus(3, 40);
    checkStatus("t2_overrun", 1'b1, 1'b1, 0);
    checkOutput("t2_ch2", 2, 30, 30, 1'b0, 1'b0);
    checkOutput("t2_ch0", 0, 16383, 0, 1'b1, 1'b0);
    checkOutput("t2_ch3", 3, 40, 40, 1'b0, 1'b0);
    ackSnap();
    checkStatus("t2_ack", 1'b0, 1'b0, 0);

    // Close and ack on the same edge
    applyStimulus(0, 5);
    applyStimulus(0, 6);
    checkStatus("t3_first", 1'b1, 1'b0, 0);
    applyStimulus(1, 8);
    snapAck = 1'b1;
    applyStimulus(1, 9);
    snapAck = 1'b0;
    checkStatus("t3_close_ack", 1'b1, 1'b0, 0);
    checkOutput("t3_ch1", 1, 8, 9, 1'b0, 1'b0);
    checkOutput("t3_ch0", 0, 16383, 0, 1'b1, 1'b0);
    ackSnap();

    // Manual close after 1000 samples
    window = '0;
    for (int c = 0; c < 4; c++) begin
      expMin[c] = '1;
      expMax[c] = '0;
    end
    for (int i = 0; i < 1000; i++) begin
      int v;
      v = (i * 7919 + 123) % 16384;
      if (W'(v) < expMin[i % 4]) expMin[i % 4] = W'(v);
      if (W'(v) > expMax[i % 4]) expMax[i % 4] = W'(v);
      applyStimulus(i % 4, v);
    end
    checkStatus("t4_count1000", 1'b0, 1'b0, 1000);
    forceClose = 1'b1;
    tick();
    forceClose = 1'b0;
    checkStatus("t4_force", 1'b1, 1'b0, 0);
    for (int c = 0; c < 4; c++)
      checkOutput("t4_extremes", c, int'(expMin[c]), int'(expMax[c]), 1'b0, 1'b0);
    ackSnap();
    forceClose = 1'b1;
    tick();
    forceClose = 1'b0;
    checkStatus("t4_force_empty", 1'b1, 1'b0, 0);
    checkAllEmpty("t4_empty");
    ackSnap();

    // Lowering window mid-run closes on the next valid sample
    applyStimulus(1, 300);
    applyStimulus(1, 100);
    applyStimulus(1, 200);
    checkStatus("t5_count3", 1'b0, 1'b0, 3);
    window = CW'(2);
    applyStimulus(1, 400);
    checkStatus("t5_close", 1'b1, 1'b0, 0);
    checkOutput("t5_ch1", 1, 100, 400, 1'b0, 1'b0);
    ackSnap();

    // Enable dropped mid-window discards the window
    window = CW'(4);
    applyStimulus(2, 11);
    applyStimulus(2, 12);
    applyStimulus(2, 13);
    enable = 1'b0;
    tick();
    checkStatus("t6_disable", 1'b0, 1'b0, 0);
    checkOutput("t6_ch2", 2, 16383, 0, 1'b1, 1'b0);
    checkOutput("t6_ch1_kept", 1, 100, 400, 1'b0, 1'b0);
    enable = 1'b1;
    tick(); tick();

    // Reset mid-window takes effect immediately
    applyStimulus(0, 1);
    applyStimulus(0, 2);
    resetN = 1'b0;
    #1;
    checkStatus("t7_reset_status", 1'b0, 1'b0, 0);
    checkOutput("t7_reset_read", 1, 16383, 0, 1'b1, 1'b1);
    tick();
    resetN = 1'b1;
    tick(); tick();
    checkOutput("t7_bank_lost", 1, 16383, 0, 1'b1, 1'b0);

    // Boundary values on channel 3, then address sweep
    window = CW'(2);
    applyStimulus(3, 0);
    applyStimulus(3, 16383);
    checkStatus("t8_close", 1'b1, 1'b0, 0);
    checkOutput("t8_ch3", 3, 0, 16383, 1'b0, 1'b0);
    checkOutput("t8_sweep0", 0, 16383, 0, 1'b1, 1'b0);
    checkOutput("t8_sweep1", 1, 16383, 0, 1'b1, 1'b0);
    checkOutput("t8_sweep2", 2, 16383, 0, 1'b1, 1'b0);
    checkOutput("t8_sweep3", 3, 0, 16383, 1'b0, 1'b0);
    ackSnap();
    checkStatus("t8_ack", 1'b0, 1'b0, 0);

    tick(); tick(); tick();
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minmax_window_ctl.md
# minmax_window_ctl

Multi-channel windowed min/max scheduler for the unsigned min/max tracking datapath. It accepts a time-multiplexed sample stream tagged with a channel index and keeps per-channel running min/max accumulators. It closes measurement windows on a programmable valid-sample count or a manual strobe, and snapshots every channel into a readout bank. Firmware collects the results through a valid/ack handshake that flags overruns. The block sits between the ADC sample mux and the local-bus register readout.

## Interface
- width, 14, sample width, unsigned
- chan_bits, 2, channel index width; chans = 2**chan_bits
- cnt_width, 16, window-length and sample-counter width
- clk  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run control; low forces IDLE
- xin  in  width  sample value, unsigned
- xin_valid  in  1  sample strobe
- xin_chan  in  chan_bits  channel tag of xin
- window  in  cnt_width  valid samples per window (all channels combined); 0 means manual close only
- force_close  in  1  close the current window on this edge
- snap_ack  in  1  firmware acknowledge of the snapshot
- snap_valid  out  1  snapshot bank holds unacknowledged data
- snap_overrun  out  1  sticky: a new snapshot overwrote unacknowledged data
- rd_addr  in  chan_bits  readout channel select
- rd_min  out  width  snapshot minimum of channel rd_addr
- rd_max  out  width  snapshot maximum of channel rd_addr
- rd_empty  out  1  channel rd_addr saw no samples in the snapshot window
- win_count  out  cnt_width  valid samples accepted in the current window

## Operation
- States: IDLE, ARM, RUN.
  - IDLE → ARM when enable=1.
  - ARM → RUN unconditionally, after 1 cycle.
  - Any state → IDLE when enable=0.
- IDLE and ARM initialise the accumulators:
  - acc_min = all ones, acc_max = 0, acc_empty = 1 for every channel.
  - win_count = 0.
  - Samples are ignored in these states.
- RUN, xin_valid=1: for channel xin_chan only:
  - acc_min ← min(acc_min, xin); acc_max ← max(acc_max, xin); acc_empty ← 0.
  - Unsigned compare. Ties leave the value unchanged.
  - win_count increments, saturating at 2**cnt_width−1.
- Close condition, RUN only:
  - (xin_valid=1 and window≠0 and win_count+1 ≥ window), or force_close=1.
  - The ≥ test means lowering window mid-run closes on the next valid sample.
- On a close edge:
  - Bank ← accumulator values, including the sample accepted on that same edge.
  - Accumulators and win_count reinitialise. The next window starts with the following sample, so no sample is lost or double counted.
- force_close with no samples: the snapshot is taken anyway, all channels empty (min all ones, max 0, empty 1).
- enable dropping mid-window: the window is discarded, no snapshot, and the bank is untouched.
- Handshake:
  - A close sets snap_valid.
  - snap_ack clears snap_valid and snap_overrun.
  - Close while snap_valid=1 and snap_ack=0: the bank is overwritten with the newer data and snap_overrun is set.
  - Close and snap_ack on the same edge: snap_valid stays 1 and snap_overrun is 0.
  - snap_ack while snap_valid=0: no effect.
- Readout: rd_min, rd_max and rd_empty are registered from bank[rd_addr].
- Arithmetic: compares only, no width growth. The window comparison is done at cnt_width+1 bits to avoid wrap.

## Timing
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - Accumulators and bank: min all ones, max 0, empty 1.
  - snap_valid = 0, snap_overrun = 0, win_count = 0.
  - rd_min = all ones, rd_max = 0, rd_empty = 1.
- Reset mid-window: all of the above takes effect immediately, and any pending snapshot is lost.
- Sample to accumulator: 1 cycle.
- Closing sample edge to snap_valid high: snap_valid is high in the cycle after the closing edge. The bank is updated on that same edge.
- rd_addr to rd_min/rd_max/rd_empty: 1 cycle latency. A rd_addr change in the cycle of a close returns the new bank 1 cycle later.
- enable rise to first accepted sample: 2 cycles (IDLE→ARM, ARM→RUN).

## Test plan
- Window behaviour: reset, enable, window=4; samples ch0: 100, 50, 200 and ch1: 7 → snap_valid next cycle. Expected snapshot:
  - ch0: min 50, max 200, empty 0.
  - ch1: min 7, max 7.
  - ch2, ch3: empty, min 16383, max 0.
  - win_count back to 0.
- Back-to-back windows: window=2, continuous valid samples with no ack for two windows → snap_overrun=1 and the bank holds the second window. Then ack → snap_valid=0 and snap_overrun=0.
- Simultaneous close and ack on the same edge → snap_valid stays 1 and snap_overrun stays 0.
- Manual close: window=0; 1000 samples, then force_close → bank holds the extremes of all 1000 samples. force_close again with no samples → all four channels empty.
- Mid-window disruption:
  - enable low after 3 of 4 samples → no snapshot and the bank keeps its prior contents.
  - reset_n pulsed mid-window → all outputs return to their reset values within the reset cycle.
- Boundary values: samples 0 and 16383 on ch3 → min 0, max 16383. rd_addr sweep 0..3 returns each channel with 1-cycle latency.
